// File: rtl/control_lectura_pkg.sv
// Shared RTC bus package: sequencer state encoding, bus width, phase timing
// defaults and strobe idle levels used by the read, write and init sequencers.
package control_lectura_pkg;

  localparam int unsigned T_FASE_DEF = 10;
  localparam int unsigned BUS_W      = 8;
  localparam int unsigned CNT_W      = 8;   // enough for T_FASE up to 255

  localparam logic STROBE_IDLE = 1'b1;      // CS_n / RD_n / WR_n inactive
  localparam logic AD_SEL_IDLE = 1'b1;      // A/D pin rests in data mode

  typedef enum logic [2:0] {
    REPOSO,
    DIR_SET,
    DIR_HOLD,
    LEER,
    LIBERA,
    FIN,
    ESPERA
  } estado_e;

  // States whose duration is measured by the phase counter.
  function automatic logic es_fase_temporizada(input estado_e s);
    return (s == DIR_SET) || (s == DIR_HOLD) || (s == LEER) || (s == LIBERA);
  endfunction

endpackage

// File: rtl/control_lectura_contador.sv
// Phase counter: walks 0..T_FASE-1 and flags the last cycle of a bus phase.
// Shared with the write sequencer; the owner clears it on every state change.
module contador_fase
  import control_lectura_pkg::*;
#(
  parameter int unsigned T_FASE = T_FASE_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tc = (cnt_q == CNT_W'(T_FASE - 1));
    if (clr || tc) cnt_d = '0;
    else           cnt_d = cnt_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/control_lectura.sv
// RTC read-cycle responder: on Inicio_L runs address then data phase on the
// multiplexed bus, captures the byte and answers with a one-cycle Fin_L.
module control_lectura
  import control_lectura_pkg::*;
#(
  parameter int unsigned T_FASE = T_FASE_DEF,
  parameter int unsigned W      = BUS_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         Inicio_L,
  input  logic [W-1:0] dir,
  input  logic [W-1:0] AD_in,
  output logic [W-1:0] AD_out,
  output logic         AD_oe,
  output logic         AD_sel,
  output logic         CS_n,
  output logic         RD_n,
  output logic         WR_n,
  output logic [W-1:0] dato_leido,
  output logic         Fin_L
);

  estado_e        state_q, state_d;
  logic [W-1:0]   addr_q, addr_d;
  logic [W-1:0]   dato_q, dato_d;
  logic [W-1:0]   ad_out_q, ad_out_d;
  logic           ad_oe_q, ad_oe_d;
  logic           ad_sel_q, ad_sel_d;
  logic           cs_n_q, cs_n_d;
  logic           rd_n_q, rd_n_d;
  logic           wr_n_q, wr_n_d;
  logic           fin_q, fin_d;
  logic           fase_tc;
  logic           cnt_clr;

  contador_fase #(.T_FASE(T_FASE)) u_contador (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .tc    (fase_tc)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dato_d  = dato_q;
    unique case (state_q)
      REPOSO:   if (Inicio_L) begin
                  state_d = DIR_SET;
                  addr_d  = dir;
                end
      DIR_SET:  if (fase_tc) state_d = DIR_HOLD;
      DIR_HOLD: if (fase_tc) state_d = LEER;
      LEER:     if (fase_tc) begin
                  state_d = LIBERA;
                  dato_d  = AD_in;
                end
      LIBERA:   if (fase_tc) state_d = FIN;
      FIN:      state_d = ESPERA;
      ESPERA:   if (!Inicio_L) state_d = REPOSO;
      default:  state_d = REPOSO;
    endcase
    cnt_clr = (state_d != state_q) || !es_fase_temporizada(state_q);
  end

  // Bus pins are a registered decode of the current state, so they trail it by one cycle.
  always_comb begin
    ad_out_d = '0;
    ad_oe_d  = 1'b0;
    ad_sel_d = AD_SEL_IDLE;
    cs_n_d   = STROBE_IDLE;
    rd_n_d   = STROBE_IDLE;
    wr_n_d   = STROBE_IDLE;
    fin_d    = 1'b0;
    unique case (state_q)
      DIR_SET: begin
        cs_n_d   = 1'b0;
        wr_n_d   = 1'b0;
        ad_sel_d = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = addr_q;
      end
      DIR_HOLD: begin
        ad_sel_d = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = addr_q;
      end
      LEER: begin
        cs_n_d = 1'b0;
        rd_n_d = 1'b0;
      end
      FIN:     fin_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= REPOSO;
      addr_q   <= '0;
      dato_q   <= '0;
      ad_out_q <= '0;
      ad_oe_q  <= 1'b0;
      ad_sel_q <= AD_SEL_IDLE;
      cs_n_q   <= STROBE_IDLE;
      rd_n_q   <= STROBE_IDLE;
      wr_n_q   <= STROBE_IDLE;
      fin_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      dato_q   <= dato_d;
      ad_out_q <= ad_out_d;
      ad_oe_q  <= ad_oe_d;
      ad_sel_q <= ad_sel_d;
      cs_n_q   <= cs_n_d;
      rd_n_q   <= rd_n_d;
      wr_n_q   <= wr_n_d;
      fin_q    <= fin_d;
    end
  end

  assign AD_out     = ad_out_q;
  assign AD_oe      = ad_oe_q;
  assign AD_sel     = ad_sel_q;
  assign CS_n       = cs_n_q;
  assign RD_n       = rd_n_q;
  assign WR_n       = wr_n_q;
  assign dato_leido = dato_q;
  assign Fin_L      = fin_q;

endmodule

// File: tb/tb_control_lectura.sv
// Bench for control_lectura: a T_FASE=10 instance and a T_FASE=2 instance, each
// checked cycle by cycle against timing windows derived from the phase rules.
module tb_control_lectura;

  localparam int T0 = 10;
  localparam int T1 = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       inicio   [2];
  logic [7:0] dir_s    [2];
  logic [7:0] ad_in    [2];
  logic [7:0] ad_out   [2];
  logic       ad_oe    [2];
  logic       ad_sel   [2];
  logic       cs_n     [2];
  logic       rd_n     [2];
  logic       wr_n     [2];
  logic [7:0] dato     [2];
  logic       fin_l    [2];
  logic [7:0] rtc_data [2];
  logic [7:0] noise    [2];
  logic [7:0] exp_dato [2];
  int         tf       [2] = '{T0, T1};
  bit         mon_en = 1'b0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  control_lectura #(.T_FASE(T0), .W(8)) dut0 (
    .clk(clk), .reset(reset), .Inicio_L(inicio[0]), .dir(dir_s[0]), .AD_in(ad_in[0]),
    .AD_out(ad_out[0]), .AD_oe(ad_oe[0]), .AD_sel(ad_sel[0]), .CS_n(cs_n[0]),
    .RD_n(rd_n[0]), .WR_n(wr_n[0]), .dato_leido(dato[0]), .Fin_L(fin_l[0])
  );

  control_lectura #(.T_FASE(T1), .W(8)) dut1 (
    .clk(clk), .reset(reset), .Inicio_L(inicio[1]), .dir(dir_s[1]), .AD_in(ad_in[1]),
    .AD_out(ad_out[1]), .AD_oe(ad_oe[1]), .AD_sel(ad_sel[1]), .CS_n(cs_n[1]),
    .RD_n(rd_n[1]), .WR_n(wr_n[1]), .dato_leido(dato[1]), .Fin_L(fin_l[1])
  );

  // RTC model: returns its byte only while selected and strobed for read.
  assign ad_in[0] = (!cs_n[0] && !rd_n[0]) ? rtc_data[0] : noise[0];
  assign ad_in[1] = (!cs_n[1] && !rd_n[1]) ? rtc_data[1] : noise[1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    noise[0] = 8'($urandom);
    noise[1] = 8'($urandom);
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("d%0d rd_wr_overlap", d), 32'(rd_n[d] | wr_n[d]), 32'd1);
        check($sformatf("d%0d oe_during_read", d), 32'(!(ad_oe[d] && !rd_n[d])), 32'd1);
      end
    end
  end

  // k = cycles since the edge that accepted the request; outputs lag state by one.
  task automatic check_cycle(input int d, input int k, input logic [7:0] addr,
                             input logic [7:0] data, input logic [7:0] old);
    int  t;
    bit  wr_ph, rd_ph, ad_ph;
    t     = tf[d];
    wr_ph = (k >= 1) && (k <= t);
    ad_ph = (k >= 1) && (k <= 2 * t);
    rd_ph = (k >= 2 * t + 1) && (k <= 3 * t);
    check($sformatf("d%0d k%0d WR_n", d, k),   32'(wr_n[d]),   32'(!wr_ph));
    check($sformatf("d%0d k%0d RD_n", d, k),   32'(rd_n[d]),   32'(!rd_ph));
    check($sformatf("d%0d k%0d CS_n", d, k),   32'(cs_n[d]),   32'(!(wr_ph || rd_ph)));
    check($sformatf("d%0d k%0d AD_oe", d, k),  32'(ad_oe[d]),  32'(ad_ph));
    check($sformatf("d%0d k%0d AD_sel", d, k), 32'(ad_sel[d]), 32'(!ad_ph));
    check($sformatf("d%0d k%0d AD_out", d, k), 32'(ad_out[d]), ad_ph ? 32'(addr) : 32'd0);
    check($sformatf("d%0d k%0d Fin_L", d, k),  32'(fin_l[d]),  32'(k == 4 * t + 1));
    check($sformatf("d%0d k%0d dato", d, k),   32'(dato[d]),   (k >= 3 * t) ? 32'(data) : 32'(old));
  endtask

  // Call just after a negedge. Inicio_L stays high through cycle `hold`.
  task automatic run_txn(input int d, input logic [7:0] addr, input logic [7:0] data,
                         input int hold, input bit change, input logic [7:0] mid_dir);
    int         last;
    logic [7:0] old;
    old         = exp_dato[d];
    dir_s[d]    = addr;
    rtc_data[d] = data;
    inicio[d]   = 1'b1;
    last        = (hold > 4 * tf[d] + 1) ? hold : 4 * tf[d] + 1;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      check_cycle(d, k, addr, data, old);
      if (change && k == 2) dir_s[d] = mid_dir;
      if (k == hold) inicio[d] = 1'b0;
    end
    inicio[d]   = 1'b0;
    exp_dato[d] = data;
    for (int k = last + 1; k <= last + 2; k++) begin
      @(negedge clk);
      check_cycle(d, k, addr, data, old);
    end
  endtask

  initial begin
    reset       = 1'b0;
    inicio      = '{1'b0, 1'b0};
    dir_s       = '{8'h00, 8'h00};
    rtc_data    = '{8'h00, 8'h00};
    exp_dato    = '{8'h00, 8'h00};

    // Reset values, then 20 idle cycles.
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) check_cycle(d, 0, 8'h00, 8'h00, 8'h00);
    reset  = 1'b1;
    mon_en = 1'b1;
    repeat (20) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) check_cycle(d, 0, 8'h00, 8'h00, exp_dato[d]);
    end

    // Single read, request dropped mid-transaction (must not abort).
    run_txn(0, 8'h21, 8'h37, 3, 1'b0, 8'h00);
    // Held request: one pulse only, then a fresh read at 8'h22.
    run_txn(0, 8'h5C, 8'hC5, 100, 1'b0, 8'h00);
    run_txn(0, 8'h22, 8'h9E, 45, 1'b0, 8'h00);
    // Address changed during DIR_SET.
    run_txn(0, 8'h21, 8'h4B, 41, 1'b1, 8'h43);

    // Reset asserted during LEER aborts immediately.
    dir_s[0]    = 8'h6A;
    rtc_data[0] = 8'h99;
    inicio[0]   = 1'b1;
    repeat (2 * T0 + 3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort CS_n", 32'(cs_n[0]), 32'd1);
    check("abort RD_n", 32'(rd_n[0]), 32'd1);
    check("abort WR_n", 32'(wr_n[0]), 32'd1);
    check("abort AD_oe", 32'(ad_oe[0]), 32'd0);
    check("abort AD_sel", 32'(ad_sel[0]), 32'd1);
    check("abort Fin_L", 32'(fin_l[0]), 32'd0);
    check("abort dato", 32'(dato[0]), 32'd0);
    inicio[0] = 1'b0;
    exp_dato  = '{8'h00, 8'h00};
    @(negedge clk);
    #2 reset = 1'b1;
    repeat (4 * T0 + 5) begin
      @(negedge clk);
      check_cycle(0, 0, 8'h00, 8'h00, exp_dato[0]);
    end

    // Randomized reads on the default build.
    for (int i = 0; i < 4; i++)
      run_txn(0, 8'($urandom), 8'($urandom), $urandom_range(1, 60), 1'($urandom), 8'($urandom));

    // T_FASE = 2 build, back-to-back reads.
    for (int i = 0; i < 6; i++)
      run_txn(1, 8'($urandom), 8'($urandom), $urandom_range(1, 12), 1'b0, 8'h00);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
